// File: rtl/dmem_dma_if.sv
// Command and memory-bus bundle between the control logic, dmem_dma and dmem.
// The checksum wire exists only when DMA_CHECKSUM_EN is defined.
interface dmem_dma_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          start;
  logic          op;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] len;
  logic [DW-1:0] fill_val;
  logic          busy;
  logic          done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_dout;
`ifdef DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  // master: the DMA engine itself
  modport master (
    input  start, op, src, dst, len, fill_val, mem_dout,
    output busy, done, mem_we, mem_addr, mem_di
`ifdef DMA_CHECKSUM_EN
    , output checksum
`endif
  );

  // slave: the core/memory environment around the engine
  modport slave (
    output start, op, src, dst, len, fill_val, mem_dout,
    input  busy, done, mem_we, mem_addr, mem_di
`ifdef DMA_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/dmem_dma.sv
// Block COPY/FILL engine driving a single-port 256x8 data memory.
// Optional DMA_CHECKSUM_EN adds a running byte-sum of the last command's writes.
module dmem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_dma_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          op_q, op_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] wdata;

  assign wdata = op_q ? fill_q : hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          src_d  = bus.src;
          dst_d  = bus.dst;
          len_d  = bus.len;
          fill_d = bus.fill_val;
          cnt_d  = '0;
          if (bus.len == '0)  state_d = S_DONE;
          else if (bus.op)    state_d = S_WR;
          else                state_d = S_RD;
        end
      end
      S_RD: begin
        hold_d  = bus.mem_dout;
        src_d   = src_q + AW'(1);
        state_d = S_WR;
      end
      S_WR: begin
        dst_d = dst_q + AW'(1);
        cnt_d = cnt_q + AW'(1);
        if (cnt_d == len_q) state_d = S_DONE;
        else if (op_q)      state_d = S_WR;
        else                state_d = S_RD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q == S_RD) || (state_q == S_WR);
  assign bus.done     = (state_q == S_DONE);
  assign bus.mem_we   = (state_q == S_WR);
  assign bus.mem_addr = (state_q == S_RD) ? src_q : dst_q;
  assign bus.mem_di   = wdata;

`ifdef DMA_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;

  // cleared on accept so the value left after done covers only that command
  always_comb begin
    csum_d = csum_q;
    if (state_q == S_IDLE && bus.start) csum_d = '0;
    else if (state_q == S_WR)           csum_d = csum_q + wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign bus.checksum = csum_q;
`endif

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma: behavioural dmem plus a scoreboard of expected writes.
module tb_dmem_dma;

  logic clk;
  logic rst_n;
  logic load_req;

  dmem_dma_if #(.AW(8), .DW(8)) bus();

  dmem_dma #(.AW(8), .DW(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  wr_t        wq [$];
  int         n_checks = 0;
  int         n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_dout = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_di;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // every observed write must match the next expected write
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        chk("spurious_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
        chk("wr_data", 32'(bus.mem_di), 32'(e.d));
      end
    end
  end

  task automatic check_mem(input string tag);
    int mm;
    mm = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mm++;
    chk(tag, 32'(mm), 32'd0);
  endtask

  task automatic run_cmd(input logic o, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] fv, input bit dup);
    int         lat, busy_n, n;
    bit         seen;
    logic [7:0] sum, a, v;
    sum = 8'h00;
    for (int i = 0; i < int'(l); i++) begin
      a = d + 8'(i);
      v = o ? fv : ref_mem[8'(s + 8'(i))];
      ref_mem[a] = v;
      wq.push_back('{a: a, d: v});
      sum = sum + v;
    end
    lat = o ? int'(l) + 1 : 2 * int'(l) + 1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.src = s; bus.dst = d; bus.len = l; bus.fill_val = fv;
    seen = 1'b0;
    busy_n = 0;
    n = 0;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (dup && n == 2) begin
        bus.start = 1'b1; bus.op = ~o; bus.src = 8'h00; bus.dst = 8'h01;
        bus.len = 8'd3; bus.fill_val = 8'hEE;
      end
      if (dup && n == 3) bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        chk("done_latency", 32'(n), 32'(lat));
        chk("done_busy_low", 32'(bus.busy), 32'd0);
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_cycles", 32'(busy_n), 32'(lat - 1));
    @(negedge clk);
    chk("done_pulse_width", 32'(bus.done), 32'd0);
`ifdef DMA_CHECKSUM_EN
    chk("checksum", 32'(bus.checksum), 32'(sum));
`endif
    chk("wq_drained", 32'(wq.size()), 32'd0);
    check_mem("mem_image");
  endtask

  initial begin
    int dn;
    rst_n = 1'b0;
    load_req = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill_val = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[0] = 8'h01; ref_mem[1] = 8'h02; ref_mem[2] = 8'h03;
    ref_mem[8'h30] = 8'hFF; ref_mem[8'h31] = 8'h02;
    repeat (3) @(negedge clk);
    load_req = 1'b0;
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_done",  32'(bus.done),     32'd0);
    chk("rst_we",    32'(bus.mem_we),   32'd0);
    chk("rst_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_di",    32'(bus.mem_di),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 1'b0);   // FILL
    run_cmd(1'b0, 8'h00, 8'h80, 8'd3, 8'h00, 1'b0);   // COPY 1,2,3
    run_cmd(1'b1, 8'h00, 8'hFE, 8'd4, 8'h3C, 1'b0);   // FILL with dst wrap
    run_cmd(1'b1, 8'h00, 8'h90, 8'd0, 8'h77, 1'b0);   // len 0
    run_cmd(1'b0, 8'h05, 8'h91, 8'd0, 8'h00, 1'b0);
    run_cmd(1'b0, 8'h30, 8'hA0, 8'd2, 8'h00, 1'b0);   // 0xFF,0x02
    run_cmd(1'b0, 8'h00, 8'h01, 8'd5, 8'h00, 1'b0);   // overlapping replicate
    run_cmd(1'b1, 8'h00, 8'h60, 8'd4, 8'h5A, 1'b1);   // second start dropped
    run_cmd(1'b0, 8'hFE, 8'h70, 8'd4, 8'h00, 1'b0);   // src wrap
    run_cmd(1'b0, 8'h30, 8'hC0, 8'd1, 8'h00, 1'b0);

    // reset during a COPY: only the first WR (cycle 2) may land
    ref_mem[8'h40] = ref_mem[8'h20];
    wq.push_back('{a: 8'h40, d: ref_mem[8'h20]});
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.src = 8'h20; bus.dst = 8'h40; bus.len = 8'd8;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy),     32'd0);
    chk("midrst_we",   32'(bus.mem_we),   32'd0);
    chk("midrst_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    chk("midrst_no_done", 32'(dn), 32'd0);
    chk("midrst_wq", 32'(wq.size()), 32'd0);
    check_mem("midrst_mem");

    run_cmd(1'b1, 8'h00, 8'h50, 8'd1, 8'hC3, 1'b0);   // recovers after reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
